// File: rtl/frame_ring_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ring_buffer_pkg
//  Description : Shared word layout, default sizing, drop-state encoding and
//                the register-update delay macro for the frame ring buffer.
//  Revision    : 1.0 - initial release
// ============================================================================

// Register-update delay used on every nonblocking assignment; empty by default
// so the RTL stays delay-free for synthesis.
`ifndef SD
`define SD
`endif

package frame_ring_buffer_pkg;

    localparam int WORD_W     = 9;   // {eof, byte}
    localparam int EOF_BIT    = 8;   // position of the end-of-frame flag
    localparam int ADDR_W_DEF = 9;   // default pointer width (512 words)

    typedef logic [WORD_W-1:0] word_t;

    // Write-side frame handling: accepting bytes, or discarding the rest of
    // a frame that overflowed.
    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } drop_state_t;

    // Pack a byte and its end-of-frame flag into one stored word.
    function automatic word_t make_word(input logic eof, input logic [7:0] data);
        word_t w;
        w          = '0;
        w[EOF_BIT] = eof;
        w[7:0]     = data;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_ring_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ring_buffer_if
//  Description : Write stream, random-access read port and release handshake
//                between the host receive path / header decoder and the
//                frame ring buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_ring_buffer_if
    import frame_ring_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = ADDR_W + 1
);

    logic [7:0]        wr_data;
    logic              wr_eof;
    logic              wr_valid;
    logic              frame_dropped;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              frame_valid;
    logic [ADDR_W-1:0] tail;
    logic              latch_tail;
    logic [CNT_W-1:0]  frame_count;

    // Producer and consumer side, as seen from outside the buffer.
    modport master (
        output wr_data, wr_eof, wr_valid, rd_addr, latch_tail,
        input  frame_dropped, rd_data, rd_data_valid, frame_valid, tail, frame_count
    );

    // The buffer itself.
    modport slave (
        input  wr_data, wr_eof, wr_valid, rd_addr, latch_tail,
        output frame_dropped, rd_data, rd_data_valid, frame_valid, tail, frame_count
    );

endinterface

`default_nettype wire

// File: rtl/frame_ring_mem.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ring_mem
//  Description : 2**ADDR_W x WORD_W storage, one synchronous write port and
//                one asynchronous read port. Kept separate so a vendor RAM
//                primitive can be dropped in.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_ring_mem #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 9
) (
    input  wire logic              clk,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic [WORD_W-1:0] wr_data_i,
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    output logic      [WORD_W-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= `SD wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/frame_ring_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ring_buffer
//  Description : Circular frame store ahead of the header decoder. Bytes are
//                written with an EOF flag; only complete (committed) frames
//                are visible on the random-access read port, and space is
//                released when the consumer latches a new tail.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_ring_buffer
    import frame_ring_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    frame_ring_buffer_if.slave ring_if
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [ADDR_W-1:0] head_q,   head_d;    // next write address
    logic [ADDR_W-1:0] commit_q, commit_d;  // one past the last committed word
    logic [ADDR_W-1:0] tail_q,   tail_d;    // oldest unreleased word
    logic [CNT_W-1:0]  count_q,  count_d;   // committed, unreleased frames
    logic              dropped_q;
    drop_state_t       state_q;

    logic [ADDR_W-1:0] head_inc;
    logic              is_full;
    logic              wr_accept;
    logic              wr_overflow;
    logic              wr_commit;
    logic              tail_release;
    logic [ADDR_W-1:0] rd_offset;
    logic [ADDR_W-1:0] commit_span;
    word_t             wr_word;

    assign head_inc = head_q + PTR_ONE;

    // The full check uses the tail as it stands before any same-cycle latch.
    assign is_full      = (head_inc == tail_q);
    assign wr_accept    = ring_if.wr_valid && (state_q == ST_PASS) && !is_full;
    assign wr_overflow  = ring_if.wr_valid && (state_q == ST_PASS) &&  is_full;
    assign wr_commit    = wr_accept && ring_if.wr_eof;
    assign tail_release = ring_if.latch_tail && (count_q != '0);
    assign wr_word      = make_word(ring_if.wr_eof, ring_if.wr_data);

    // Next pointer and frame-count values from this cycle's write and release.
    always_comb begin
        head_d   = head_q;
        commit_d = commit_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (wr_accept) begin
            head_d = head_inc;
        end else if (wr_overflow) begin
            // Throw away the partial frame by rewinding to the commit point.
            head_d = commit_q;
        end

        if (wr_commit) begin
            commit_d = head_inc;
        end

        if (tail_release) begin
            tail_d = ring_if.rd_addr;
        end

        case ({wr_commit, tail_release})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer registers, drop pulse and the drop-state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= `SD '0;
            commit_q  <= `SD '0;
            tail_q    <= `SD '0;
            count_q   <= `SD '0;
            dropped_q <= `SD 1'b0;
            state_q   <= `SD ST_PASS;
        end else begin
            head_q    <= `SD head_d;
            commit_q  <= `SD commit_d;
            tail_q    <= `SD tail_d;
            count_q   <= `SD count_d;
            dropped_q <= `SD wr_overflow;
            case (state_q)
                ST_PASS: begin
                    // An overflow on the EOF byte already ends the frame.
                    if (wr_overflow && !ring_if.wr_eof) begin
                        state_q <= `SD ST_DROP;
                    end
                end
                ST_DROP: begin
                    // The EOF byte is discarded too; the next frame starts clean.
                    if (ring_if.wr_valid && ring_if.wr_eof) begin
                        state_q <= `SD ST_PASS;
                    end
                end
                default: state_q <= `SD ST_PASS;
            endcase
        end
    end

    frame_ring_mem #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (head_q),
        .wr_data_i (wr_word),
        .rd_addr_i (ring_if.rd_addr),
        .rd_data_o (ring_if.rd_data)
    );

    // A read address is valid when it falls in the committed span measured
    // from the tail, which keeps uncommitted bytes invisible across the wrap.
    assign rd_offset   = ring_if.rd_addr - tail_q;
    assign commit_span = commit_q - tail_q;

    assign ring_if.rd_data_valid = (rd_offset < commit_span);
    assign ring_if.frame_valid   = (count_q != '0);
    assign ring_if.frame_count   = count_q;
    assign ring_if.tail          = tail_q;
    assign ring_if.frame_dropped = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_ring_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_ring_buffer
//  Description : Scoreboard bench for frame_ring_buffer. A 512-word instance
//                covers framing, visibility, wrap, simultaneous commit/release
//                and reset; a 16-word instance covers overflow and dropping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_ring_buffer;

    // Signal selectors for the scoreboard.
    localparam int S_RD_DATA  = 0;
    localparam int S_RD_VALID = 1;
    localparam int S_FR_VALID = 2;
    localparam int S_TAIL     = 3;
    localparam int S_COUNT    = 4;
    localparam int S_DROPPED  = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frame_ring_buffer_if #(.ADDR_W(9)) bus_a ();
    frame_ring_buffer_if #(.ADDR_W(4)) bus_b ();

    frame_ring_buffer #(.ADDR_W(9)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .ring_if (bus_a)
    );

    frame_ring_buffer #(.ADDR_W(4)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .ring_if (bus_b)
    );

    typedef struct {
        int          d;
        int          s;
        logic [15:0] v;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [15:0] get_sig(input int d, input int s);
        logic [15:0] r;
        r = '0;
        if (d == 0) begin
            case (s)
                S_RD_DATA:  r = 16'(bus_a.rd_data);
                S_RD_VALID: r = 16'(bus_a.rd_data_valid);
                S_FR_VALID: r = 16'(bus_a.frame_valid);
                S_TAIL:     r = 16'(bus_a.tail);
                S_COUNT:    r = 16'(bus_a.frame_count);
                default:    r = 16'(bus_a.frame_dropped);
            endcase
        end else begin
            case (s)
                S_RD_DATA:  r = 16'(bus_b.rd_data);
                S_RD_VALID: r = 16'(bus_b.rd_data_valid);
                S_FR_VALID: r = 16'(bus_b.frame_valid);
                S_TAIL:     r = 16'(bus_b.tail);
                S_COUNT:    r = 16'(bus_b.frame_count);
                default:    r = 16'(bus_b.frame_dropped);
            endcase
        end
        return r;
    endfunction

    // Monitor: on each falling edge, compare everything queued since the
    // last one against what the DUT presents now.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e   = exp_q.pop_front();
            act = get_sig(e.d, e.s);
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.nm, act, e.v);
            end
        end
    end

    task automatic push(input int d, input int s, input logic [15:0] v, input string nm);
        exp_t e;
        e.d  = d;
        e.s  = s;
        e.v  = v;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int d, input bit v, input bit e, input logic [7:0] data,
                         input int addr, input bit lt);
        if (d == 0) begin
            bus_a.wr_valid   = v;
            bus_a.wr_eof     = e;
            bus_a.wr_data    = data;
            bus_a.rd_addr    = 9'(addr);
            bus_a.latch_tail = lt;
        end else begin
            bus_b.wr_valid   = v;
            bus_b.wr_eof     = e;
            bus_b.wr_data    = data;
            bus_b.rd_addr    = 4'(addr);
            bus_b.latch_tail = lt;
        end
    endtask

    task automatic set_addr(input int d, input int addr);
        if (d == 0) bus_a.rd_addr = 9'(addr);
        else        bus_b.rd_addr = 4'(addr);
    endtask

    // Let the monitor consume what has been queued.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [7:0] data, input bit eof);
        drive(d, 1'b1, eof, data, 0, 1'b0);
        edge_step();
        drive(d, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic latch(input int d, input int addr);
        drive(d, 1'b0, 1'b0, 8'h00, addr, 1'b1);
        edge_step();
        drive(d, 1'b0, 1'b0, 8'h00, addr, 1'b0);
    endtask

    task automatic chk(input int d, input int s, input logic [15:0] v, input string nm);
        push(d, s, v, nm);
        settle();
    endtask

    task automatic chk_rd(input int d, input int addr, input logic [15:0] data,
                          input bit valid, input string nm);
        set_addr(d, addr);
        if (valid) push(d, S_RD_DATA, data, {nm, "_data"});
        push(d, S_RD_VALID, 16'(valid), {nm, "_valid"});
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        drive(1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- reset state ----
        push(0, S_COUNT,    16'd0, "rst_count");
        push(0, S_FR_VALID, 16'd0, "rst_frame_valid");
        push(0, S_TAIL,     16'd0, "rst_tail");
        push(0, S_DROPPED,  16'd0, "rst_dropped");
        push(0, S_RD_VALID, 16'd0, "rst_rd_valid");
        settle();

        // ---- single frame 05 02 AA(eof) at 0..2 ----
        wr(0, 8'h05, 1'b0);
        wr(0, 8'h02, 1'b0);
        wr(0, 8'hAA, 1'b1);
        push(0, S_COUNT,    16'd1, "single_count");
        push(0, S_FR_VALID, 16'd1, "single_frame_valid");
        settle();
        chk_rd(0, 0, 16'h005, 1'b1, "single_rd0");
        chk_rd(0, 1, 16'h002, 1'b1, "single_rd1");
        chk_rd(0, 2, 16'h1AA, 1'b1, "single_rd2");
        chk_rd(0, 3, 16'h000, 1'b0, "single_rd3");
        latch(0, 3);
        push(0, S_TAIL,     16'd3, "single_latch_tail");
        push(0, S_COUNT,    16'd0, "single_latch_count");
        push(0, S_FR_VALID, 16'd0, "single_latch_fv");
        settle();

        // ---- partial frame stays invisible until its EOF ----
        wr(0, 8'h11, 1'b0);
        wr(0, 8'h22, 1'b0);
        push(0, S_FR_VALID, 16'd0, "partial_frame_valid");
        settle();
        chk_rd(0, 3, 16'h000, 1'b0, "partial_rd3");
        chk_rd(0, 4, 16'h000, 1'b0, "partial_rd4");
        wr(0, 8'h33, 1'b1);
        chk(0, S_FR_VALID, 16'd1, "partial_done_fv");
        chk_rd(0, 3, 16'h011, 1'b1, "partial_done_rd3");
        chk_rd(0, 5, 16'h133, 1'b1, "partial_done_rd5");
        latch(0, 6);
        chk(0, S_COUNT, 16'd0, "partial_latch_count");

        // ---- simultaneous committing EOF and latch_tail ----
        wr(0, 8'h44, 1'b0);   // 6
        wr(0, 8'h55, 1'b1);   // 7, commit -> 8
        wr(0, 8'h66, 1'b0);   // 8
        drive(0, 1'b1, 1'b1, 8'h77, 8, 1'b1);  // 9 with eof, latch tail at 8
        edge_step();
        drive(0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        push(0, S_COUNT, 16'd1, "simul_count");
        push(0, S_TAIL,  16'd8, "simul_tail");
        settle();
        chk_rd(0, 8,  16'h066, 1'b1, "simul_rd8");
        chk_rd(0, 9,  16'h177, 1'b1, "simul_rd9");
        chk_rd(0, 10, 16'h000, 1'b0, "simul_rd10");
        chk_rd(0, 7,  16'h000, 1'b0, "simul_rd7");
        latch(0, 10);
        chk(0, S_COUNT, 16'd0, "simul_release_count");

        // ---- wrap: advance to 510 with one long dummy frame ----
        for (int i = 0; i < 500; i++) begin
            wr(0, 8'(i), (i == 499));
        end
        chk(0, S_COUNT, 16'd1, "dummy_count");
        latch(0, 510);
        chk(0, S_TAIL, 16'd510, "dummy_tail");
        wr(0, 8'hA1, 1'b0);   // 510
        wr(0, 8'hB2, 1'b0);   // 511
        wr(0, 8'hC3, 1'b0);   // 0
        wr(0, 8'hD4, 1'b1);   // 1
        chk(0, S_COUNT, 16'd1, "wrap_count");
        chk_rd(0, 510, 16'h0A1, 1'b1, "wrap_rd510");
        chk_rd(0, 511, 16'h0B2, 1'b1, "wrap_rd511");
        chk_rd(0, 0,   16'h0C3, 1'b1, "wrap_rd0");
        chk_rd(0, 1,   16'h1D4, 1'b1, "wrap_rd1");
        chk_rd(0, 2,   16'h000, 1'b0, "wrap_rd2");
        latch(0, 2);
        push(0, S_TAIL,  16'd2, "wrap_latch_tail");
        push(0, S_COUNT, 16'd0, "wrap_latch_count");
        settle();

        // ---- overflow on the 16-word instance ----
        for (int i = 0; i < 10; i++) begin
            wr(1, 8'(8'h10 + i), (i == 9));   // 0..9, commit at 10
        end
        chk(1, S_COUNT, 16'd1, "ovf_first_count");
        for (int i = 0; i < 9; i++) begin
            wr(1, 8'(8'h20 + i), (i == 8));
            // 5 bytes fit (10..14); the 6th hits the full ring.
            chk(1, S_DROPPED, 16'((i == 5) ? 1 : 0), $sformatf("ovf_dropped_b%0d", i));
        end
        chk(1, S_COUNT, 16'd1, "ovf_after_drop_count");
        chk_rd(1, 9,  16'h119, 1'b1, "ovf_rd9");
        chk_rd(1, 10, 16'h000, 1'b0, "ovf_rd10");
        wr(1, 8'h31, 1'b0);   // 10
        wr(1, 8'h32, 1'b0);   // 11
        wr(1, 8'h33, 1'b1);   // 12
        chk(1, S_COUNT, 16'd2, "ovf_next_count");
        chk(1, S_DROPPED, 16'd0, "ovf_next_dropped");
        chk_rd(1, 10, 16'h031, 1'b1, "ovf_next_rd10");
        chk_rd(1, 12, 16'h133, 1'b1, "ovf_next_rd12");
        chk_rd(1, 13, 16'h000, 1'b0, "ovf_next_rd13");

        // ---- asynchronous reset mid-write with two frames stored ----
        wr(0, 8'h01, 1'b0);   // 2
        wr(0, 8'h02, 1'b1);   // 3
        wr(0, 8'h03, 1'b0);   // 4
        wr(0, 8'h04, 1'b1);   // 5
        chk(0, S_COUNT, 16'd2, "prerst_count");
        drive(0, 1'b1, 1'b0, 8'h05, 2, 1'b0);
        edge_step();
        drive(0, 1'b1, 1'b0, 8'h06, 2, 1'b0);
        #1;
        rst = 1'b1;
        push(0, S_COUNT,    16'd0, "arst_count");
        push(0, S_FR_VALID, 16'd0, "arst_frame_valid");
        push(0, S_TAIL,     16'd0, "arst_tail");
        push(0, S_RD_VALID, 16'd0, "arst_rd_valid");
        settle();
        edge_step();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        wr(0, 8'h0E, 1'b0);
        wr(0, 8'h0F, 1'b1);
        chk(0, S_COUNT, 16'd1, "postrst_count");
        chk_rd(0, 0, 16'h00E, 1'b1, "postrst_rd0");
        chk_rd(0, 1, 16'h10F, 1'b1, "postrst_rd1");
        chk_rd(0, 2, 16'h000, 1'b0, "postrst_rd2");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            settle();
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_ring_buffer.md
Name: frame_ring_buffer

Overview:
Circular frame store that sits directly upstream of the frame header decoder. It accepts a byte stream with end-of-frame marks from the host receive path and stores each byte as a 9-bit word: bit 8 is EOF, bits 7:0 are data. It exposes committed frames through a random-access read port driven by the consumer's address. Storage is released only when the consumer latches a new tail pointer.

Parameters:
- ADDR_W, 9, pointer width; depth = 2**ADDR_W words.
- CNT_W, ADDR_W+1, width of the committed-frame counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- wr_data  input  8  byte to store
- wr_eof  input  1  qualifies wr_data as the last byte of its frame
- wr_valid  input  1  write strobe; one byte per cycle, no backpressure
- frame_dropped  output  1  one-cycle pulse when a frame is discarded for overflow
- rd_addr  input  ADDR_W  consumer read address (absolute, wraps modulo depth)
- rd_data  output  9  {eof, byte} at rd_addr; combinational, zero latency
- rd_data_valid  output  1  rd_addr lies inside committed frames
- frame_valid  output  1  at least one complete frame is committed
- tail  output  ADDR_W  current release pointer
- latch_tail  input  1  consumer finished a frame: tail <= rd_addr, one frame released
- frame_count  output  CNT_W  number of committed, unreleased frames

Behaviour:
- Reset (asynchronous, active-high) clears all of the following to 0: head, commit, tail, frame_count, frame_dropped, dropping flag. Memory contents are don't-care.
- Pointers: head (next write), commit (end of last committed frame), tail (oldest unreleased word). All arithmetic is modulo 2**ADDR_W.
- Full condition: head+1 == tail. Usable capacity is depth-1 words.
- Write (wr_valid, not dropping, not full):
  - mem[head] <= {wr_eof, wr_data}; head <= head+1.
  - If wr_eof, also commit <= head+1 and frame_count increments.
- Overflow (wr_valid while full):
  - The byte is not written.
  - head <= commit, rewinding the partial frame.
  - frame_dropped pulses for 1 cycle.
  - If !wr_eof, enter dropping. If wr_eof, dropping is not entered.
- Dropping state:
  - Every wr_valid byte is discarded.
  - The byte carrying wr_eof is discarded and dropping clears on the following edge.
  - No further frame_dropped pulses.
  - The next frame starts clean.
- rd_data = mem[rd_addr], asynchronous read.
- rd_data_valid = ((rd_addr - tail) mod depth) < ((commit - tail) mod depth). It is therefore 0 when frame_count == 0.
- frame_valid = (frame_count != 0).
- latch_tail:
  - tail <= rd_addr and frame_count decrements.
  - latch_tail while frame_count == 0 is ignored: tail and count are unchanged.
- Simultaneous committing EOF write and latch_tail: frame_count unchanged; both pointer updates take effect.
- Freeing space: a write in the same cycle as latch_tail uses the pre-latch tail for the full check.
- Wrap-around: a frame may straddle address depth-1 -> 0. The consumer's rd_addr wraps identically.
- Uncommitted bytes (between commit and head) are never reported valid.
- Reset asserted mid-frame discards everything. The first frame after reset starts at address 0.

Decomposition:
- Shared package/include: frame word width (9), EOF bit index (8), default ADDR_W, and the existing `SD delay macro, used on all nonblocking assignments.
- One natural sub-module: frame_ring_mem (dual-port, 1 write synchronous, 1 read asynchronous, 2**ADDR_W x 9) so the FPGA RAM primitive can be swapped.
- Pointer, commit and drop logic stays in the top.

Test Plan:
- Single frame: write 0x05, 0x02, 0xAA(eof).
  - frame_count=1, frame_valid=1.
  - rd_addr 0..2 give 0x005, 0x002, 0x1AA with rd_data_valid=1; rd_addr=3 is invalid.
  - latch_tail with rd_addr=3 gives tail=3, frame_count=0.
- Partial frame visibility: write 2 bytes without eof -> rd_data_valid=0 at addr 0, frame_valid=0. Eof on the 3rd byte -> valid.
- Wrap: pre-advance pointers to 510 via dummy frames, then write a 4-byte frame -> stored at 510, 511, 0, 1; data valid at all four; latch at rd_addr=2 gives tail=2.
- Overflow: ADDR_W=4 (15 usable). Commit a 10-byte frame, then stream a 9-byte frame.
  - 5 bytes accepted, then frame_dropped pulses once and head returns to 10.
  - Remaining bytes through eof are discarded; frame_count stays 1.
  - The next 3-byte frame commits normally.
- Simultaneous EOF commit and latch_tail -> frame_count unchanged; tail and commit both update.
- Asynchronous reset asserted mid-write with 2 frames stored -> all outputs 0 immediately; the next frame is stored at address 0.
